// File: rtl/bidir_pad_bank_pkg.sv
// Shared types and boundary-scan cell indexing for the pad bank.
// The chain holds data cells first (0..W-1), then enable cells (W..2W-1).
package slipstream_pad_pkg;

    localparam int PAD_MAX_WIDTH = 32;

    // Widest bank vector; a bank uses the low WIDTH bits.
    typedef logic [PAD_MAX_WIDTH-1:0] pad_vec_t;

    function automatic int data_cell(input int n);
        return n;
    endfunction

    function automatic int en_cell(input int n, input int width);
        return width + n;
    endfunction

endpackage

// File: rtl/bidir_pad_bank_if.sv
// Core/pin-side and scan signals of one pad bank.
interface bidir_pad_bank_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A, TN, I, O, E, ZI;
    logic             EN;
    logic             SCAN_MODE, SCAN_CAPTURE, SCAN_SHIFT, SCAN_UPDATE, SI, SO;

    modport master (
        output A, TN, EN, I, SCAN_MODE, SCAN_CAPTURE, SCAN_SHIFT, SCAN_UPDATE, SI,
        input  O, E, ZI, SO
    );

    modport slave (
        input  A, TN, EN, I, SCAN_MODE, SCAN_CAPTURE, SCAN_SHIFT, SCAN_UPDATE, SI,
        output O, E, ZI, SO
    );
endinterface

// File: rtl/bidir_pad_bank_cell.sv
// One pad: registered drive enable/output plus the ZI register, which is
// frozen for TURN_CYCLES after the pad releases the bus.
module pad_cell_turn #(
    parameter int unsigned TURN_CYCLES = 2
) (
    input  logic MasterClock,
    input  logic MasterReset,
    input  logic scanMode,
    input  logic tn,
    input  logic en,
    input  logic a,
    input  logic padIn,
    input  logic syncIn,
    input  logic updData,
    input  logic updEn,
    output logic o,
    output logic e,
    output logic zi
);
    localparam int CntW = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES + 1);

    logic [CntW-1:0] cnt;
    logic            eNext, oNext;

    // Functional O looks at the pre-edge E; scan O follows the update cell directly.
    always_comb begin
        eNext = tn & ~en;
        oNext = e ? a : padIn;
        if (scanMode) begin
            eNext = updEn;
            oNext = updEn ? updData : padIn;
        end
    end

    always_ff @(posedge MasterClock or posedge MasterReset) begin
        if (MasterReset) begin
            o   <= 1'b0;
            e   <= 1'b0;
            zi  <= 1'b0;
            cnt <= '0;
        end else begin
            e <= eNext;
            o <= oNext;
            if (e && !eNext)       cnt <= CntW'(TURN_CYCLES);
            else if (!e && eNext)  cnt <= '0;
            else if (cnt != '0)    cnt <= cnt - 1'b1;
            if (cnt == '0) zi <= syncIn;
        end
    end
endmodule

// File: rtl/bidir_pad_bank.sv
// Bank of WIDTH bidirectional pad cells with input synchroniser and a
// capture/shift/update boundary-scan chain.
module bidir_pad_bank
    import slipstream_pad_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TURN_CYCLES = 2
) (
    input logic             MasterClock,
    input logic             MasterReset,
    bidir_pad_bank_if.slave pads
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] syncQ;
    logic [WIDTH-1:0]                  syncIn, oVec, eVec, ziVec;
    logic [2*WIDTH-1:0]                shiftQ, updQ, capVec;

    assign syncIn  = syncQ[SYNC_STAGES-1];
    assign pads.O  = oVec;
    assign pads.E  = eVec;
    assign pads.ZI = ziVec;
    assign pads.SO = shiftQ[0];

    always_ff @(posedge MasterClock or posedge MasterReset) begin
        if (MasterReset) begin
            syncQ <= '0;
        end else begin
            syncQ[0] <= pads.I;
            for (int k = 1; k < SYNC_STAGES; k++) syncQ[k] <= syncQ[k-1];
        end
    end

    always_comb begin
        capVec = '0;
        for (int n = 0; n < WIDTH; n++) begin
            capVec[data_cell(n)]       = syncIn[n];
            capVec[en_cell(n, WIDTH)]  = eVec[n];
        end
    end

    // Capture has priority over shift; update samples the pre-edge chain.
    always_ff @(posedge MasterClock or posedge MasterReset) begin
        if (MasterReset) begin
            shiftQ <= '0;
            updQ   <= '0;
        end else begin
            if (pads.SCAN_CAPTURE)    shiftQ <= capVec;
            else if (pads.SCAN_SHIFT) shiftQ <= {pads.SI, shiftQ[2*WIDTH-1:1]};
            if (pads.SCAN_UPDATE)     updQ   <= shiftQ;
        end
    end

    for (genvar n = 0; n < WIDTH; n++) begin : gPad
        pad_cell_turn #(.TURN_CYCLES(TURN_CYCLES)) uCell (
            .MasterClock (MasterClock),
            .MasterReset (MasterReset),
            .scanMode    (pads.SCAN_MODE),
            .tn          (pads.TN[n]),
            .en          (pads.EN),
            .a           (pads.A[n]),
            .padIn       (pads.I[n]),
            .syncIn      (syncIn[n]),
            .updData     (updQ[n]),
            .updEn       (updQ[WIDTH+n]),
            .o           (oVec[n]),
            .e           (eVec[n]),
            .zi          (ziVec[n])
        );
    end
endmodule

// File: tb/tb_bidir_pad_bank.sv
// Directed checks of the pad bank: drive, receive, turnaround hold, scan chain, reset.
module tb_bidir_pad_bank;
    import slipstream_pad_pkg::*;

    localparam int W = 8;

    logic MasterClock = 1'b0;
    logic MasterReset;
    int   nChk = 0;
    int   nErr = 0;
    logic [15:0] soExp, shPat, got16;

    bidir_pad_bank_if #(.WIDTH(W)) bus ();

    bidir_pad_bank #(.WIDTH(W), .SYNC_STAGES(2), .TURN_CYCLES(2)) dut (
        .MasterClock (MasterClock),
        .MasterReset (MasterReset),
        .pads        (bus)
    );

    always #5 MasterClock = ~MasterClock;

    task automatic chk(input string tag, input pad_vec_t got, input pad_vec_t exp);
        nChk++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge MasterClock);
        #1;
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_o"},  pad_vec_t'(bus.O),  'h0);
        chk({tag, "_e"},  pad_vec_t'(bus.E),  'h0);
        chk({tag, "_zi"}, pad_vec_t'(bus.ZI), 'h0);
        chk({tag, "_so"}, pad_vec_t'(bus.SO), 'h0);
    endtask

    initial begin
        MasterReset      = 1'b1;
        bus.A            = '0;
        bus.TN           = '0;
        bus.EN           = 1'b0;
        bus.I            = '0;
        bus.SCAN_MODE    = 1'b0;
        bus.SCAN_CAPTURE = 1'b0;
        bus.SCAN_SHIFT   = 1'b0;
        bus.SCAN_UPDATE  = 1'b0;
        bus.SI           = 1'b0;
        #1;
        chkZero("rst0");
        #1 MasterReset = 1'b0;

        // drive path
        bus.TN = 8'hFF; bus.A = 8'hA5;
        tick();
        chk("drv_e1", pad_vec_t'(bus.E), 'hFF);
        chk("drv_o1", pad_vec_t'(bus.O), 'h00);
        tick();
        chk("drv_o2", pad_vec_t'(bus.O), 'hA5);
        bus.EN = 1'b1;
        tick();
        chk("drv_en", pad_vec_t'(bus.E), 'h00);

        // receive path, after the release hold has expired
        bus.TN = '0; bus.EN = 1'b0;
        tick(3);
        bus.I = 8'h3C;
        tick(2);
        chk("rx_early", pad_vec_t'(bus.ZI), 'h00);
        tick();
        chk("rx_3rd", pad_vec_t'(bus.ZI), 'h3C);

        // turnaround hold on pad 0
        bus.TN = 8'h01; bus.I = 8'h00;
        tick(4);
        chk("ta_e", pad_vec_t'(bus.E), 'h01);
        chk("ta_zi", pad_vec_t'(bus.ZI), 'h00);
        bus.TN = 8'h00; bus.I = 8'h01;
        tick();
        tick();
        chk("ta_h1", pad_vec_t'(bus.ZI), 'h00);
        tick();
        chk("ta_h2", pad_vec_t'(bus.ZI), 'h00);
        tick();
        chk("ta_rel", pad_vec_t'(bus.ZI), 'h01);

        // re-driving mid-hold cancels the rest of the hold
        bus.TN = 8'h01; bus.I = 8'h00;
        tick(4);
        chk("tc_zi", pad_vec_t'(bus.ZI), 'h00);
        bus.TN = 8'h00; bus.I = 8'h01;
        tick();
        bus.TN = 8'h01;
        tick();
        tick();
        chk("tc_clr", pad_vec_t'(bus.ZI), 'h01);

        // capture then shift out, LSB first
        bus.TN = 8'h0F; bus.I = 8'h81;
        tick(3);
        chk("sc_e", pad_vec_t'(bus.E), 'h0F);
        bus.SCAN_CAPTURE = 1'b1;
        tick();
        bus.SCAN_CAPTURE = 1'b0; bus.SCAN_SHIFT = 1'b1; bus.SI = 1'b0;
        soExp = 16'h0F81;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("so%0d", k), pad_vec_t'(bus.SO), pad_vec_t'(soExp[k]));
            tick();
        end

        // shift in data=5A en=F0, update, switch to scan drive
        shPat = 16'hF05A;
        for (int k = 0; k < 16; k++) begin
            bus.SI = shPat[k];
            tick();
        end
        bus.SCAN_SHIFT = 1'b0; bus.SCAN_UPDATE = 1'b1;
        tick();
        bus.SCAN_UPDATE = 1'b0;
        chk("up_func_e", pad_vec_t'(bus.E), 'h0F);
        bus.SCAN_MODE = 1'b1; bus.I = 8'h0C;
        tick();
        chk("up_e", pad_vec_t'(bus.E), 'hF0);
        chk("up_o", pad_vec_t'(bus.O), 'h5C);

        // capture and shift together: capture only
        tick();
        bus.SCAN_CAPTURE = 1'b1; bus.SCAN_SHIFT = 1'b1;
        tick();
        chk("cs_so", pad_vec_t'(bus.SO), 'h0);
        bus.SCAN_CAPTURE = 1'b0; bus.SI = 1'b1;
        for (int k = 0; k < 16; k++) begin
            got16[k] = bus.SO;
            tick();
        end
        chk("cs_chain", pad_vec_t'(got16), 'hF00C);

        // async reset mid-shift clears outputs and the chain
        chk("pre_rst_so", pad_vec_t'(bus.SO), 'h1);
        #2 MasterReset = 1'b1;
        #1;
        chkZero("rst1");
        #2 MasterReset = 1'b0;
        bus.SCAN_MODE = 1'b0; bus.TN = '0; bus.SI = 1'b0;
        tick();
        chk("post_rst_so", pad_vec_t'(bus.SO), 'h0);
        chk("post_rst_e", pad_vec_t'(bus.E), 'h00);

        $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
        $finish;
    end
endmodule
